vend_sequencer: RTL and testbench

Clocked controller for the drink vending machine's front panel and dispense path. Debounces the two active-low panel buttons and turns them into select, confirm and cancel events. Tracks coin credit and the selected drink, and drives the active-low selection LEDs. Sequences one dispense transaction at a time to the dispense mechanism over a valid/ready handshake.

---
 rtl/vend_sequencer.sv | 233 +++++++++++++++++++++++
 tb/tb_vend_sequencer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vend_sequencer.sv
// vend_sequencer: front-panel and dispense controller for the drink vending machine.
// Debounces two active-low buttons into SELECT / CONFIRM / CANCEL events, tracks coin
// credit and the selected drink, and runs one dispense transaction at a time over a
// valid/ready handshake with a timeout.
//
// Ports:
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_btn1, i_btn2        raw buttons A (select) / B (confirm), active-low, asynchronous
//   i_coin                one-cycle pulse, +1 credit
//   i_dispense_ready      mechanism accepts the pending request
//   o_lights              active-low selection LEDs (bit0 drink 1 .. bit2 drink 3)
//   o_dispense_valid      dispense request pending
//   o_dispense_sel        drink being dispensed (1..3)
//   o_credit              saturating credit
//   o_refund/_valid       credit returned on cancel, one-cycle strobe
//   o_deny                one-cycle pulse: confirm rejected
//   o_fault               one-cycle pulse: dispense timeout
//
// Optional feature macro: STOCK_TRACK_EN (per-slot stock counters, empty-slot LED blink).
module vend_sequencer #(
  parameter int unsigned DEBOUNCE_CYCLES  = 16,
  parameter int unsigned PRICE            = 2,
  parameter int unsigned DISPENSE_TIMEOUT = 64
`ifdef STOCK_TRACK_EN
  ,
  parameter int unsigned STOCK_INIT       = 3
`endif
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_btn1,
  input  logic       i_btn2,
  input  logic       i_coin,
  input  logic       i_dispense_ready,
  output logic [2:0] o_lights,
  output logic       o_dispense_valid,
  output logic [1:0] o_dispense_sel,
  output logic [3:0] o_credit,
  output logic [3:0] o_refund,
  output logic       o_refund_valid,
  output logic       o_deny,
  output logic       o_fault
);

  localparam int unsigned DbW  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned TmoW = $clog2(DISPENSE_TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StDispense, StDone} state_e;

  function automatic logic [2:0] sel_to_lights(input logic [1:0] s);
    case (s)
      2'd1:    return 3'b110;
      2'd2:    return 3'b101;
      2'd3:    return 3'b011;
      default: return 3'b111;
    endcase
  endfunction

  // ---------------- input conditioning (index 0 = button A, 1 = button B) -----------
  logic [1:0]     w_btn;
  logic [1:0]     r_sync1, r_sync2, r_db, r_db_prev;
  logic [DbW-1:0] r_cnt [2];

  assign w_btn = {i_btn2, i_btn1};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1   <= 2'b11;
      r_sync2   <= 2'b11;
      r_db      <= 2'b11;
      r_db_prev <= 2'b11;
      for (int i = 0; i < 2; i++) r_cnt[i] <= '0;
    end else begin
      r_sync1   <= w_btn;
      r_sync2   <= r_sync1;
      r_db_prev <= r_db;
      for (int i = 0; i < 2; i++) begin
        if (r_sync2[i] != r_db[i]) begin
          if (r_cnt[i] == DbW'(DEBOUNCE_CYCLES - 1)) begin
            r_db[i]  <= r_sync2[i];
            r_cnt[i] <= '0;
          end else begin
            r_cnt[i] <= r_cnt[i] + 1'b1;
          end
        end else begin
          r_cnt[i] <= '0;
        end
      end
    end
  end

  // ---------------- event decode ----------------
  logic       r_chord;
  logic       w_both_low, w_cancel, w_select, w_confirm;
  logic [1:0] w_fall;

  assign w_both_low = ~r_db[0] & ~r_db[1];
  assign w_fall     = r_db_prev & ~r_db;
  assign w_cancel   = w_both_low & ~r_chord;
  // A chord latches until both buttons are back up; single-button events are masked meanwhile.
  assign w_select   = w_fall[0] & ~w_both_low & ~r_chord;
  assign w_confirm  = w_fall[1] & ~w_both_low & ~r_chord;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)          r_chord <= 1'b0;
    else if (w_both_low)   r_chord <= 1'b1;
    else if (&r_db)        r_chord <= 1'b0;
  end

  // ---------------- credit arithmetic ----------------
  state_e          r_state;
  logic [1:0]      r_sel;
  logic [2:0]      r_lights;
  logic [TmoW-1:0] r_tmo;
  logic            w_debit;
  logic [4:0]      w_credit_sum;
  logic [3:0]      w_credit_nxt;
  logic            w_in_stock;

  assign w_debit = (r_state == StDispense) & i_dispense_ready;

  // Debit only happens with credit >= PRICE, so the 5-bit sum never underflows.
  always_comb begin
    w_credit_sum = {1'b0, o_credit} + {4'b0, i_coin};
    if (w_debit) w_credit_sum = w_credit_sum - 5'(PRICE);
    w_credit_nxt = (w_credit_sum > 5'd15) ? 4'hf : w_credit_sum[3:0];
  end

  // ---------------- optional stock tracking ----------------
`ifdef STOCK_TRACK_EN
  logic [3:0]  r_stock [3];
  logic [19:0] r_blink;
  logic [3:0]  w_stock_cur;

  always_comb begin
    w_stock_cur = '0;
    case (r_sel)
      2'd1:    w_stock_cur = r_stock[0];
      2'd2:    w_stock_cur = r_stock[1];
      2'd3:    w_stock_cur = r_stock[2];
      default: w_stock_cur = '0;
    endcase
  end

  assign w_in_stock = (w_stock_cur != 4'd0);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < 3; i++) r_stock[i] <= 4'(STOCK_INIT);
      r_blink <= '0;
    end else begin
      r_blink <= r_blink + 1'b1;
      if (w_debit) begin
        for (int i = 0; i < 3; i++) begin
          if (r_sel == 2'(i + 1)) r_stock[i] <= r_stock[i] - 4'd1;
        end
      end
    end
  end

  // An empty selected slot blanks its LED during the upper half of the blink period.
  assign o_lights = r_lights |
                    (((r_sel != 2'd0) && !w_in_stock && r_blink[19]) ? 3'b111 : 3'b000);
`else
  assign w_in_stock = 1'b1;
  assign o_lights   = r_lights;
`endif

  // ---------------- transaction FSM ----------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state          <= StIdle;
      r_sel            <= 2'd0;
      r_lights         <= 3'b111;
      r_tmo            <= '0;
      o_dispense_valid <= 1'b0;
      o_dispense_sel   <= 2'd0;
      o_credit         <= 4'd0;
      o_refund         <= 4'd0;
      o_refund_valid   <= 1'b0;
      o_deny           <= 1'b0;
      o_fault          <= 1'b0;
    end else begin
      o_refund_valid <= 1'b0;
      o_deny         <= 1'b0;
      o_fault        <= 1'b0;
      o_credit       <= w_credit_nxt;
      case (r_state)
        StIdle: begin
          if (w_cancel) begin
            o_refund       <= o_credit;
            o_refund_valid <= 1'b1;
            o_credit       <= {3'b000, i_coin};
            r_sel          <= 2'd0;
            r_lights       <= 3'b111;
          end else if (w_select) begin
            r_sel    <= (r_sel == 2'd3) ? 2'd1 : r_sel + 2'd1;
            r_lights <= sel_to_lights((r_sel == 2'd3) ? 2'd1 : r_sel + 2'd1);
          end else if (w_confirm) begin
            if ((r_sel != 2'd0) && (o_credit >= 4'(PRICE)) && w_in_stock) begin
              r_state          <= StDispense;
              o_dispense_valid <= 1'b1;
              o_dispense_sel   <= r_sel;
              r_tmo            <= '0;
            end else begin
              o_deny <= 1'b1;
            end
          end
        end
        StDispense: begin
          // Panel events are dropped here; the handshake wins over a same-cycle timeout.
          if (i_dispense_ready) begin
            o_dispense_valid <= 1'b0;
            r_state          <= StDone;
          end else if (r_tmo == TmoW'(DISPENSE_TIMEOUT - 1)) begin
            o_dispense_valid <= 1'b0;
            o_fault          <= 1'b1;
            r_state          <= StIdle;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end
        StDone: begin
          r_sel    <= 2'd0;
          r_lights <= 3'b111;
          r_state  <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_vend_sequencer.sv
// tb_vend_sequencer: directed self-checking bench for vend_sequencer with default
// parameters (DEBOUNCE_CYCLES=16, PRICE=2, DISPENSE_TIMEOUT=64). Inputs are driven 1 time
// unit after the rising edge; pulse outputs are tallied on the falling edge.
module tb_vend_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn1 = 1'b1;
  logic       btn2 = 1'b1;
  logic       coin = 1'b0;
  logic       ready = 1'b0;
  logic [2:0] lights;
  logic       dispense_valid;
  logic [1:0] dispense_sel;
  logic [3:0] credit;
  logic [3:0] refund;
  logic       refund_valid;
  logic       deny;
  logic       fault;

  int n_chk = 0;
  int n_pass = 0;

  // Pulse tallies, written only by the monitor below.
  int         deny_cnt = 0;
  int         refund_cnt = 0;
  int         fault_cnt = 0;
  int         valid_hi = 0;
  logic [3:0] last_refund = '0;

  always #5 clk = ~clk;

  vend_sequencer dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_btn1           (btn1),
    .i_btn2           (btn2),
    .i_coin           (coin),
    .i_dispense_ready (ready),
    .o_lights         (lights),
    .o_dispense_valid (dispense_valid),
    .o_dispense_sel   (dispense_sel),
    .o_credit         (credit),
    .o_refund         (refund),
    .o_refund_valid   (refund_valid),
    .o_deny           (deny),
    .o_fault          (fault)
  );

  always @(negedge clk) begin
    if (deny) deny_cnt++;
    if (fault) fault_cnt++;
    if (dispense_valid) valid_hi++;
    if (refund_valid) begin
      refund_cnt++;
      last_refund = refund;
    end
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // 22 cycles covers 2 sync stages + 16 debounce cycles + event decode.
  task automatic press(input logic a, input logic b);
    if (a) btn1 = 1'b0;
    if (b) btn2 = 1'b0;
    tick(22);
  endtask

  task automatic release_btn(input logic a, input logic b);
    if (a) btn1 = 1'b1;
    if (b) btn2 = 1'b1;
    tick(22);
  endtask

  task automatic put_coin(input int n);
    repeat (n) begin
      coin = 1'b1;
      tick(1);
      coin = 1'b0;
      tick(1);
    end
  endtask

  task automatic ready_pulse();
    ready = 1'b1;
    tick(1);
    ready = 1'b0;
  endtask

  int d0, r0, f0, v0, k;

  initial begin
    // Reset values.
    tick(3);
    check("rst_lights", lights, 7);
    check("rst_valid", dispense_valid, 0);
    check("rst_dsel", dispense_sel, 0);
    check("rst_credit", credit, 0);
    check("rst_refund", refund, 0);
    check("rst_pulses", {refund_valid, deny, fault}, 0);
    rst_n = 1'b1;
    tick(2);

    // Bouncing A (toggle every 5 cycles) never settles long enough.
    for (int i = 0; i < 12; i++) begin
      btn1 = ~btn1;
      tick(5);
    end
    btn1 = 1'b1;
    tick(22);
    check("bounce_lights", lights, 7);

    // Clean A press: exactly one SELECT, release is not an event.
    press(1'b1, 1'b0);
    check("sel1_lights", lights, 6);
    release_btn(1'b1, 1'b0);
    check("sel1_after_rel", lights, 6);

    // 3 coins, sel=2, confirm, ready after 5 cycles.
    put_coin(3);
    check("credit3", credit, 3);
    press(1'b1, 1'b0);
    release_btn(1'b1, 1'b0);
    check("sel2_lights", lights, 5);
    d0 = deny_cnt;
    press(1'b0, 1'b1);
    check("disp_valid", dispense_valid, 1);
    check("disp_sel2", dispense_sel, 2);
    release_btn(1'b0, 1'b1);
    tick(5);
    check("disp_credit_hold", credit, 3);
    ready_pulse();
    check("hs_valid_low", dispense_valid, 0);
    check("hs_credit", credit, 1);
    tick(1);
    check("done_lights", lights, 7);
    check("disp_no_deny", deny_cnt - d0, 0);

    // Insufficient credit: deny, nothing else changes.
    press(1'b1, 1'b0);
    release_btn(1'b1, 1'b0);
    check("sel1b_lights", lights, 6);
    d0 = deny_cnt;
    v0 = valid_hi;
    press(1'b0, 1'b1);
    release_btn(1'b0, 1'b1);
    check("deny_pulse", deny_cnt - d0, 1);
    check("deny_credit", credit, 1);
    check("deny_no_valid", valid_hi - v0, 0);
    check("deny_lights", lights, 6);

    // Cancel chord with 4 credits and sel=3.
    put_coin(3);
    check("credit4", credit, 4);
    press(1'b1, 1'b0);
    release_btn(1'b1, 1'b0);
    press(1'b1, 1'b0);
    release_btn(1'b1, 1'b0);
    check("sel3_lights", lights, 3);
    r0 = refund_cnt;
    d0 = deny_cnt;
    press(1'b1, 1'b1);
    check("cancel_pulses", refund_cnt - r0, 1);
    check("cancel_refund", last_refund, 4);
    check("cancel_credit", credit, 0);
    check("cancel_lights", lights, 7);
    // Re-press B while A is still held: no second cancel, no confirm (would deny at sel=0).
    release_btn(1'b0, 1'b1);
    press(1'b0, 1'b1);
    check("chord_no_recancel", refund_cnt - r0, 1);
    check("chord_no_confirm", deny_cnt - d0, 0);
    // Re-press A while B is held: no select.
    release_btn(1'b1, 1'b0);
    press(1'b1, 1'b0);
    check("chord_no_select", lights, 7);
    release_btn(1'b1, 1'b1);
    check("chord_release", refund_cnt - r0, 1);
    // After full release events are live again.
    press(1'b1, 1'b0);
    release_btn(1'b1, 1'b0);
    check("rearm_lights", lights, 6);

    // Timeout: ready held low, coin accepted during DISPENSE.
    put_coin(2);
    f0 = fault_cnt;
    v0 = valid_hi;
    press(1'b0, 1'b1);
    check("tmo_valid", dispense_valid, 1);
    check("tmo_dsel", dispense_sel, 1);
    put_coin(1);
    check("tmo_coin_credit", credit, 3);
    release_btn(1'b0, 1'b1);
    k = 0;
    while (fault_cnt == f0 && k < 100) begin
      tick(1);
      k++;
    end
    check("tmo_fault", fault_cnt - f0, 1);
    check("tmo_valid_cycles", valid_hi - v0, 64);
    check("tmo_valid_low", dispense_valid, 0);
    check("tmo_credit", credit, 3);
    check("tmo_sel_kept", lights, 6);
    // Back in IDLE: a fresh confirm dispenses drink 1.
    press(1'b0, 1'b1);
    check("retry_valid", dispense_valid, 1);
    ready_pulse();
    check("retry_credit", credit, 1);
    tick(1);
    check("retry_lights", lights, 7);
    release_btn(1'b0, 1'b1);

`ifdef STOCK_TRACK_EN
    // Drink 1 already dispensed once above; two more empty the slot, the next is denied.
    put_coin(5);
    for (int i = 0; i < 2; i++) begin
      press(1'b1, 1'b0);
      release_btn(1'b1, 1'b0);
      press(1'b0, 1'b1);
      check("stock_valid", dispense_valid, 1);
      ready_pulse();
      release_btn(1'b0, 1'b1);
    end
    check("stock_credit", credit, 2);
    press(1'b1, 1'b0);
    release_btn(1'b1, 1'b0);
    d0 = deny_cnt;
    v0 = valid_hi;
    press(1'b0, 1'b1);
    release_btn(1'b0, 1'b1);
    check("stock_deny", deny_cnt - d0, 1);
    check("stock_no_valid", valid_hi - v0, 0);
    check("stock_credit_kept", credit, 2);
`endif

    // Saturation at 15, then refund the full amount.
    put_coin(16);
    check("credit_sat", credit, 15);
    r0 = refund_cnt;
    press(1'b1, 1'b1);
    check("sat_refund", last_refund, 15);
    check("sat_refund_pulse", refund_cnt - r0, 1);
    check("sat_credit_clr", credit, 0);
    release_btn(1'b1, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
